spart_fifo: RTL and testbench
=============================

# spart_fifo

Parametrised serial port (SPART) with independent transmit and receive FIFOs, 16x-oversampled receiver, and sticky error reporting. Sits between the processor's SPART interface and the `txd`/`rxd` pins, on the 100 MHz core clock. Lets software queue multiple bytes per transmit burst and lets received bytes accumulate without being lost while the processor is busy.

## Interface
- `DATA_W`, 8: data bits per frame (5–9).
- `TX_DEPTH`, 16: transmit FIFO entries (power of two, ≥2).
- `RX_DEPTH`, 16: receive FIFO entries (power of two, ≥2).
- `OVS_DIV`, 54: clocks per oversample tick; bit period = 16·OVS_DIV clocks (54 → 115200 baud at 100 MHz).

- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `send`  in  1  push `send_data` into the TX FIFO; ignored while `full`=1.
- `send_data`  in  DATA_W  byte to transmit.
- `full`  out  1  TX FIFO full.
- `rd`  in  1  pop the RX FIFO head; ignored while `rcv_valid`=0.
- `rcv_valid`  out  1  RX FIFO non-empty.
- `receive_data`  out  DATA_W  RX FIFO head (first-word fall-through).
- `rx_count`  out  clog2(RX_DEPTH)+1  RX FIFO occupancy.
- `frame_err`  out  1  sticky: stop bit sampled low.
- `overrun_err`  out  1  sticky: byte completed while RX FIFO full.
- `err_clr`  in  1  clears both sticky flags.
- `txd`  out  1  serial out, idle high.
- `rxd`  in  1  serial in, asynchronous.

## Operation
- Reset: `txd`=1, `full`=0, `rcv_valid`=0, `receive_data`=0, `rx_count`=0, both error flags 0; both FIFOs empty; both FSMs IDLE; all counters 0.
- Frame: start (0), DATA_W data bits LSB first, stop (1).
- TX FSM: IDLE → START → DATA → STOP → IDLE. In IDLE with FIFO non-empty, pop head into shift register and enter START. Each state lasts exactly one bit period, timed by a bit counter that restarts on every load. From STOP, pops the next entry directly if present (back-to-back frames, no idle gap).
- RX: `rxd` passes through a 2-FF synchroniser. Tick counter free-runs at OVS_DIV.
- RX FSM: IDLE → START → DATA → STOP → IDLE. IDLE: on synchronised falling edge, reset the sub-bit counter and enter START. START: at tick 8, sample; if high, false start → IDLE. Otherwise sample each subsequent 16 ticks (bit centre). STOP: stop sample high → push byte; low → set `frame_err`, discard byte. Either way → IDLE.
- Push onto a full RX FIFO: byte dropped, `overrun_err` set. `rd` and push in the same cycle on a full FIFO: pop first, push accepted, no overrun.
- TX FIFO `send` while `full`: ignored, contents unchanged. `send` on empty FIFO simultaneous with FSM pop is legal; occupancy stays correct.
- `err_clr` coincident with a new error event: the new error wins (flag remains 1).
- Pointers wrap modulo depth; full/empty derived from a depth+1-bit count.

## Timing
- `send` at cycle N (FIFO empty, TX idle): pop at N+1, `txd` low from N+2; frame occupies (DATA_W+2)·16·OVS_DIV clocks.
- `full` and `rcv_valid` update the cycle after the causing push/pop.
- `receive_data` valid in the same cycle `rcv_valid` is high; `rd` at cycle M presents the next entry at M+1.
- RX byte visible on `rcv_valid` 2 cycles after the stop-bit centre sample (synchroniser excluded).
- Error flags rise 1 cycle after the stop sample/overrun event; `err_clr` takes effect next cycle.
- Reset mid-frame: `txd` returns high next cycle, partial frames are discarded, FIFOs are emptied.

## Configuration
- `SPART_PARITY_EN`: defined → even parity bit inserted between the last data bit and stop on TX. RX checks it; mismatch sets sticky `parity_err` output (1 bit, cleared by `err_clr`) and discards the byte. Frame becomes DATA_W+3 bits.
- Undefined → no parity bit, no `parity_err` port.

## Test plan
- OVS_DIV=4, send 0xA5 → `txd` low from N+2 for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, stop high; total 640 clocks.
- Push 17 bytes 0x00..0x10 with TX_DEPTH=16 while TX idle → `full` after the 17th push attempt cycle window; 0x10 is accepted only after the first pop; bytes go out in order, back-to-back with no idle gap.
- Loop `txd`→`rxd`, send 0x3C, 0xFF, 0x00 → `rx_count`=3, `receive_data` reads 0x3C, 0xFF, 0x00 on successive `rd`; flags 0.
- Drive 17 frames into RX_DEPTH=16 with no `rd` → `overrun_err`=1, FIFO holds first 16; `err_clr` → 0.
- Drive frame 0x55 with stop bit low → `frame_err`=1, `rx_count` unchanged; 3-tick glitch low on idle line → no byte, no error.
- `SPART_PARITY_EN`: inject 0x07 with parity 0 (wrong; even parity requires 1) → `parity_err`=1, byte discarded; with parity 1 → byte 0x07 received.

Source files
------------

// File: rtl/spart_fifo.sv
// SPART with independent TX/RX FIFOs, a 16x-oversampled receiver and sticky error flags.
// Define SPART_PARITY_EN to add an even parity bit and the parity_err output.
module spart_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned OVS_DIV  = 54
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      send,
  input  logic [DATA_W-1:0]         send_data,
  output logic                      full,
  input  logic                      rd,
  output logic                      rcv_valid,
  output logic [DATA_W-1:0]         receive_data,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      frame_err,
  output logic                      overrun_err,
`ifdef SPART_PARITY_EN
  output logic                      parity_err,
`endif
  input  logic                      err_clr,
  output logic                      txd,
  input  logic                      rxd
);

  localparam int unsigned TXAW     = $clog2(TX_DEPTH);
  localparam int unsigned RXAW     = $clog2(RX_DEPTH);
  localparam int unsigned BIT_CLKS = 16 * OVS_DIV;
  localparam int unsigned BCW      = $clog2(BIT_CLKS);
  localparam int unsigned OVW      = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int unsigned BIW      = $clog2(DATA_W + 1);
`ifdef SPART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {StTxIdle, StTxStart, StTxData, StTxParity, StTxStop} tx_state_e;
  typedef enum logic [2:0] {StRxIdle, StRxStart, StRxData, StRxParity, StRxStop} rx_state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TXAW-1:0]   tx_wptr_q, tx_rptr_q;
  logic [TXAW:0]     tx_cnt_q;
  logic              tx_push, tx_pop, tx_empty;

  assign tx_empty = (tx_cnt_q == '0);
  assign full     = (tx_cnt_q == (TXAW+1)'(TX_DEPTH));
  assign tx_push  = send && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + TXAW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TXAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + (TXAW+1)'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - (TXAW+1)'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= send_data;
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_e         tx_state_q, tx_state_d;
  logic [BCW-1:0]    tx_clk_cnt_q;
  logic [BIW-1:0]    tx_bit_idx_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_par_q;
  logic              tx_bit_done, tx_last_bit;

  assign tx_bit_done = (tx_clk_cnt_q == BCW'(BIT_CLKS - 1));
  assign tx_last_bit = (tx_bit_idx_q == BIW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) tx_state_q <= StTxIdle;
    else     tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      StTxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = StTxStart;
        end
      end
      StTxStart:  if (tx_bit_done) tx_state_d = StTxData;
      StTxData:   if (tx_bit_done && tx_last_bit) tx_state_d = PAR_EN ? StTxParity : StTxStop;
      StTxParity: if (tx_bit_done) tx_state_d = StTxStop;
      StTxStop: begin
        // Chain straight into the next frame so bursts have no idle gap.
        if (tx_bit_done) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_state_d = StTxStart;
          end else begin
            tx_state_d = StTxIdle;
          end
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state_q)
      StTxStart:  txd = 1'b0;
      StTxData:   txd = tx_shift_q[0];
      StTxParity: txd = tx_par_q;
      default:    txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_clk_cnt_q <= '0;
      tx_bit_idx_q <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
    end else if (tx_pop) begin
      tx_clk_cnt_q <= '0;
      tx_bit_idx_q <= '0;
      tx_shift_q   <= tx_mem[tx_rptr_q];
      tx_par_q     <= ^tx_mem[tx_rptr_q];
    end else if (tx_state_q != StTxIdle) begin
      if (tx_bit_done) begin
        tx_clk_cnt_q <= '0;
        if (tx_state_q == StTxData) begin
          tx_shift_q   <= tx_shift_q >> 1;
          tx_bit_idx_q <= tx_bit_idx_q + BIW'(1);
        end
      end else begin
        tx_clk_cnt_q <= tx_clk_cnt_q + BCW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- RX front end
  logic           rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [OVW-1:0] ovs_cnt_q;
  logic           rx_tick, rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      ovs_cnt_q  <= '0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      ovs_cnt_q  <= rx_tick ? '0 : ovs_cnt_q + OVW'(1);
    end
  end

  assign rx_tick = (ovs_cnt_q == OVW'(OVS_DIV - 1));
  assign rx_fall = rxd_prev_q && !rxd_sync_q;

  // ---------------------------------------------------------------- RX FSM
  rx_state_e         rx_state_q, rx_state_d;
  logic [3:0]        rx_sub_q;
  logic [BIW-1:0]    rx_bit_idx_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_par_bad_q, rx_push_q;
  logic              rx_mid, rx_start_smp, rx_last_bit;
  logic              rx_stop_smp, rx_good, frame_set;

  assign rx_start_smp = rx_tick && (rx_sub_q == 4'd7);
  assign rx_mid       = rx_tick && (rx_sub_q == 4'd15);
  assign rx_last_bit  = (rx_bit_idx_q == BIW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) rx_state_q <= StRxIdle;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      StRxIdle:   if (rx_fall) rx_state_d = StRxStart;
      StRxStart:  if (rx_start_smp) rx_state_d = rxd_sync_q ? StRxIdle : StRxData;
      StRxData:   if (rx_mid && rx_last_bit) rx_state_d = PAR_EN ? StRxParity : StRxStop;
      StRxParity: if (rx_mid) rx_state_d = StRxStop;
      StRxStop:   if (rx_mid) rx_state_d = StRxIdle;
      default:    rx_state_d = StRxIdle;
    endcase
  end

  always_comb begin
    rx_stop_smp = (rx_state_q == StRxStop) && rx_mid;
    rx_good     = rx_stop_smp && rxd_sync_q && !(PAR_EN && rx_par_bad_q);
    frame_set   = rx_stop_smp && !rxd_sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sub_q     <= '0;
      rx_bit_idx_q <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
      rx_push_q    <= 1'b0;
    end else begin
      rx_push_q <= rx_good;
      if (rx_state_q == StRxIdle) begin
        if (rx_fall) begin
          rx_sub_q     <= '0;
          rx_bit_idx_q <= '0;
          rx_par_bad_q <= 1'b0;
        end
      end else if (rx_tick) begin
        // Restart the sub-bit phase at the start-bit centre; later samples wrap at 16.
        rx_sub_q <= (rx_state_q == StRxStart && rx_sub_q == 4'd7) ? 4'd0 : rx_sub_q + 4'd1;
      end
      if (rx_state_q == StRxData && rx_mid) begin
        rx_shift_q   <= {rxd_sync_q, rx_shift_q[DATA_W-1:1]};
        rx_bit_idx_q <= rx_bit_idx_q + BIW'(1);
      end
      if (rx_state_q == StRxParity && rx_mid) rx_par_bad_q <= rxd_sync_q ^ (^rx_shift_q);
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RXAW-1:0]   rx_wptr_q, rx_rptr_q;
  logic [RXAW:0]     rx_cnt_q;
  logic              rx_full, rx_pop, rx_accept, ovr_set;

  assign rcv_valid    = (rx_cnt_q != '0);
  assign rx_full      = (rx_cnt_q == (RXAW+1)'(RX_DEPTH));
  assign rx_pop       = rd && rcv_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign rx_accept    = rx_push_q && (!rx_full || rx_pop);
  assign ovr_set      = rx_push_q && !rx_accept;
  assign receive_data = rcv_valid ? rx_mem[rx_rptr_q] : '0;
  assign rx_count     = rx_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_accept) rx_wptr_q <= rx_wptr_q + RXAW'(1);
      if (rx_pop)    rx_rptr_q <= rx_rptr_q + RXAW'(1);
      case ({rx_accept, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + (RXAW+1)'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - (RXAW+1)'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem[rx_wptr_q] <= rx_shift_q;
  end

  // ---------------------------------------------------------------- sticky flags
  logic frame_err_q, overrun_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= frame_set || (frame_err_q && !err_clr);
      overrun_err_q <= ovr_set || (overrun_err_q && !err_clr);
    end
  end

  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

`ifdef SPART_PARITY_EN
  logic parity_err_q, parity_set;

  assign parity_set = rx_stop_smp && rxd_sync_q && rx_par_bad_q;

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_set || (parity_err_q && !err_clr);
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_spart_fifo.sv
// Directed self-checking bench for spart_fifo (OVS_DIV=4, 64-clock bit period).
// Parity scenarios are compiled in only when SPART_PARITY_EN is defined.
module tb_spart_fifo;

  localparam int unsigned OVS = 4;
  localparam int unsigned BIT = 16 * OVS;
`ifdef SPART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * BIT;

  logic       clk = 1'b0;
  logic       rst, send, rd, err_clr, rxd_drv, loop_en;
  logic [7:0] send_data, receive_data;
  logic       full, rcv_valid, frame_err, overrun_err, txd, rxd;
  logic [4:0] rx_count;
`ifdef SPART_PARITY_EN
  logic       parity_err;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign rxd = loop_en ? txd : rxd_drv;

  spart_fifo #(
    .DATA_W  (8),
    .TX_DEPTH(16),
    .RX_DEPTH(16),
    .OVS_DIV (OVS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .send_data   (send_data),
    .full        (full),
    .rd          (rd),
    .rcv_valid   (rcv_valid),
    .receive_data(receive_data),
    .rx_count    (rx_count),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef SPART_PARITY_EN
    .parity_err  (parity_err),
`endif
    .err_clr     (err_clr),
    .txd         (txd),
    .rxd         (rxd)
  );

  // Expected line level for bit slot idx of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned idx);
    logic [7:0]  v;
    int unsigned k;
    v = b;
    k = idx - 1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[k[2:0]];
    if (NBITS == 11 && idx == 9) return ^v;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from slot start..FRAME-1 where txd disagrees with the expected frame.
  task automatic watch_frame(input logic [7:0] b, input int unsigned start, output int bad);
    bad = 0;
    for (int unsigned c = start; c < FRAME; c++) begin
      if (txd !== exp_bit(b, c / BIT)) bad++;
      step();
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [7:0] v;
    v = b;
    rxd_drv = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd_drv = v[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    if (NBITS == 11) begin
      rxd_drv = par;
      repeat (BIT) @(posedge clk);
      #1;
    end
    rxd_drv = stop;
    repeat (BIT) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 1'b0; rd = 1'b0; err_clr = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    send_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", txd); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    tests++;
    if (rcv_valid !== 1'b0) begin fails++; $display("FAIL reset_rcv_valid: got %b want 0", rcv_valid); end
    tests++;
    if (receive_data !== 8'h00) begin
      fails++; $display("FAIL reset_receive_data: got %h want 00", receive_data);
    end
    tests++;
    if (rx_count !== 5'd0) begin fails++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests++;
    if (overrun_err !== 1'b0) begin
      fails++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err);
    end
  endtask

  task automatic test_tx_frame();
    int bad;
    send_data = 8'hA5;
    send = 1'b1;
    step();
    send = 1'b0;
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL tx_n1_idle: got %b want 1", txd); end
    step();
    for (int unsigned b = 0; b < NBITS; b++) begin
      bad = 0;
      for (int c = 0; c < int'(BIT); c++) begin
        if (txd !== exp_bit(8'hA5, b)) bad++;
        step();
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL tx_a5_slot%0d: %0d of %0d cycles wrong, want txd=%b", b, bad, BIT,
                 exp_bit(8'hA5, b));
      end
    end
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL tx_a5_end_idle: got %b want 1", txd); end
  endtask

  task automatic test_tx_fifo();
    int bad;
    send = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      send_data = 8'(i);
      step();
    end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fifo_full: got %b want 1", full); end
    send_data = 8'hEE;
    step();
    send = 1'b0;
    tests++;
    if (full !== 1'b1) begin fails++; $display("FAIL fifo_full_ignore: got %b want 1", full); end
    // The first frame began two cycles after the first push; 16 cycles of it have elapsed.
    watch_frame(8'h00, 16, bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL fifo_frame0: %0d cycles wrong, want 0", bad); end
    tests++;
    if (full !== 1'b0) begin fails++; $display("FAIL fifo_full_after_pop: got %b want 0", full); end
    for (int i = 1; i <= 16; i++) begin
      watch_frame(8'(i), 0, bad);
      tests++;
      if (bad != 0) begin fails++; $display("FAIL fifo_frame%0d: %0d cycles wrong, want 0", i, bad); end
    end
    bad = 0;
    for (int c = 0; c < int'(BIT); c++) begin
      if (txd !== 1'b1) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL fifo_idle_after: %0d low cycles, want 0", bad); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h3C; exp_q[1] = 8'hFF; exp_q[2] = 8'h00;
    loop_en = 1'b1;
    send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_data = exp_q[i];
      step();
    end
    send = 1'b0;
    for (int c = 0; c < int'(4 * FRAME); c++) begin
      if (rx_count == 5'd3) break;
      step();
    end
    tests++;
    if (rx_count !== 5'd3) begin fails++; $display("FAIL loop_rx_count: got %0d want 3", rx_count); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (receive_data !== exp_q[i]) begin
        fails++; $display("FAIL loop_data%0d: got %h want %h", i, receive_data, exp_q[i]);
      end
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    tests++;
    if (rcv_valid !== 1'b0) begin fails++; $display("FAIL loop_drained: got %b want 0", rcv_valid); end
    tests++;
    if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      fails++; $display("FAIL loop_flags: got frame=%b overrun=%b want 0 0", frame_err, overrun_err);
    end
    repeat (FRAME) @(posedge clk);
    #1;
    loop_en = 1'b0;
  endtask

  task automatic test_overrun();
    int bad;
    logic [7:0] v;
    for (int i = 0; i < 17; i++) begin
      v = 8'(8'h80 + i);
      drive_frame(v, ^v, 1'b1);
    end
    repeat (4) step();
    tests++;
    if (overrun_err !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", overrun_err); end
    tests++;
    if (rx_count !== 5'd16) begin fails++; $display("FAIL ovr_count: got %0d want 16", rx_count); end
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL ovr_frame_err: got %b want 0", frame_err); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (receive_data !== 8'(8'h80 + i)) bad++;
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL ovr_contents: %0d entries wrong, want 0", bad); end
    tests++;
    if (rcv_valid !== 1'b0) begin fails++; $display("FAIL ovr_drained: got %b want 0", rcv_valid); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests++;
    if (overrun_err !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun_err); end
  endtask

  task automatic test_frame_err();
    drive_frame(8'h55, ^8'h55, 1'b0);
    repeat (4) step();
    tests++;
    if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    tests++;
    if (rx_count !== 5'd0) begin fails++; $display("FAIL ferr_count: got %0d want 0", rx_count); end
    tests++;
    if (overrun_err !== 1'b0) begin fails++; $display("FAIL ferr_overrun: got %b want 0", overrun_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
    rxd_drv = 1'b0;
    repeat (3 * OVS) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (FRAME) @(posedge clk);
    #1;
    tests++;
    if (rx_count !== 5'd0) begin fails++; $display("FAIL glitch_count: got %0d want 0", rx_count); end
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
  endtask

`ifdef SPART_PARITY_EN
  task automatic test_parity();
    drive_frame(8'h07, 1'b0, 1'b1);
    repeat (4) step();
    tests++;
    if (parity_err !== 1'b1) begin fails++; $display("FAIL par_bad_flag: got %b want 1", parity_err); end
    tests++;
    if (rx_count !== 5'd0) begin fails++; $display("FAIL par_bad_count: got %0d want 0", rx_count); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drive_frame(8'h07, 1'b1, 1'b1);
    repeat (4) step();
    tests++;
    if (parity_err !== 1'b0) begin fails++; $display("FAIL par_ok_flag: got %b want 0", parity_err); end
    tests++;
    if (rx_count !== 5'd1) begin fails++; $display("FAIL par_ok_count: got %0d want 1", rx_count); end
    tests++;
    if (receive_data !== 8'h07) begin fails++; $display("FAIL par_ok_data: got %h want 07", receive_data); end
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe();
    int bad;
    send_data = 8'h81;
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL midrst_txd: got %b want 1", txd); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL midrst_full: got %b want 0", full); end
    bad = 0;
    for (int c = 0; c < int'(FRAME); c++) begin
      if (txd !== 1'b1) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midrst_quiet: %0d low cycles, want 0", bad); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_fifo();
    test_loopback();
    test_overrun();
    test_frame_err();
`ifdef SPART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
